coin_arbiter: RTL

COIN_ARBITER -- requirements
Module: coin_arbiter

---
 rtl/coin_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/coin_arbiter.sv
// Two-slot coin arbiter: per-slot 2-entry coin FIFOs, round-robin issue of nickel/dime strobes to the vending core.
// Coin sampled on edge k strobes after edge k+1 at the earliest; vm_open=1 holds issue while slots keep queueing/rejecting.
module coin_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic a_nickel,
    input  logic a_dime,
    input  logic b_nickel,
    input  logic b_dime,
    input  logic vm_open,
    output logic nickel,
    output logic dime,
    output logic a_full,
    output logic b_full,
    output logic a_reject,
    output logic b_reject,
    output logic last_b
);

    localparam logic [1:0] LP_DEPTH = DEPTH[1:0];

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_a_cnt, r_b_cnt;
    logic [1:0] r_a_q, r_b_q;
    logic       r_ptr_b;
    logic       r_nickel, r_dime, r_a_rej, r_b_rej, r_last_b;

    logic       w_pop_en;
    logic       w_a_coin, w_b_coin, w_a_push, w_b_push, w_a_rej, w_b_rej;
    logic       w_a_ne, w_b_ne, w_grant_a, w_grant_b, w_grant, w_pop_type;
    logic [1:0] w_a_q_nxt, w_b_q_nxt;

    // Head lives in bit 0; a pop shifts before the new coin lands behind the survivors.
    function automatic logic [1:0] fifo_nxt(input logic [1:0] q, input logic [1:0] cnt,
                                            input logic pop, input logic push, input logic din);
        logic [1:0] nq;
        logic       widx;
        nq   = q;
        widx = (cnt != 2'd0) && !pop;
        if (pop)
            nq[0] = q[1];
        if (push)
            nq[widx] = din;
        return nq;
    endfunction

    assign w_a_coin = a_nickel ^ a_dime;
    assign w_b_coin = b_nickel ^ b_dime;
    assign w_a_push = w_a_coin && (r_a_cnt < LP_DEPTH);
    assign w_b_push = w_b_coin && (r_b_cnt < LP_DEPTH);
    assign w_a_rej  = (a_nickel & a_dime) | (w_a_coin & (r_a_cnt == LP_DEPTH));
    assign w_b_rej  = (b_nickel & b_dime) | (w_b_coin & (r_b_cnt == LP_DEPTH));
    assign w_a_ne   = (r_a_cnt != 2'd0);
    assign w_b_ne   = (r_b_cnt != 2'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_pop_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (vm_open)
                    w_state_nxt = ST_LOCK;
                else
                    w_pop_en = 1'b1;
            end
            ST_LOCK: begin
                if (!vm_open)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_grant_a  = w_pop_en & w_a_ne & (!w_b_ne | !r_ptr_b);
    assign w_grant_b  = w_pop_en & w_b_ne & (!w_a_ne |  r_ptr_b);
    assign w_grant    = w_grant_a | w_grant_b;
    assign w_pop_type = w_grant_b ? r_b_q[0] : r_a_q[0];
    assign w_a_q_nxt  = fifo_nxt(r_a_q, r_a_cnt, w_grant_a, w_a_push, a_dime);
    assign w_b_q_nxt  = fifo_nxt(r_b_q, r_b_cnt, w_grant_b, w_b_push, b_dime);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_a_cnt  <= 2'd0;
            r_b_cnt  <= 2'd0;
            r_a_q    <= 2'b00;
            r_b_q    <= 2'b00;
            r_ptr_b  <= 1'b0;
            r_nickel <= 1'b0;
            r_dime   <= 1'b0;
            r_a_rej  <= 1'b0;
            r_b_rej  <= 1'b0;
            r_last_b <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a_cnt  <= r_a_cnt + {1'b0, w_a_push} - {1'b0, w_grant_a};
            r_b_cnt  <= r_b_cnt + {1'b0, w_b_push} - {1'b0, w_grant_b};
            r_a_q    <= w_a_q_nxt;
            r_b_q    <= w_b_q_nxt;
            r_nickel <= w_grant & !w_pop_type;
            r_dime   <= w_grant &  w_pop_type;
            r_a_rej  <= w_a_rej;
            r_b_rej  <= w_b_rej;
            if (w_grant) begin
                r_ptr_b  <= w_grant_a;
                r_last_b <= w_grant_b;
            end
        end
    end

    assign nickel   = r_nickel;
    assign dime     = r_dime;
    assign a_reject = r_a_rej;
    assign b_reject = r_b_rej;
    assign last_b   = r_last_b;
    assign a_full   = (r_a_cnt == LP_DEPTH);
    assign b_full   = (r_b_cnt == LP_DEPTH);

endmodule
